ipad_event_arb: RTL
===================

# ipad_event_arb

Sequencing controller for a bank of `IPAD` input pads. It synchronises and debounces each pad level, then detects level changes. Pending change events from all pads are shared onto one valid/ready event port through a round-robin arbiter. It sits between the pad ring and fabric logic that consumes pad-change notifications.

## Interface
- `N_PADS`, 4: number of pads served (2..16).
- `SYNC_STAGES`, 2: synchroniser flops per pad (≥2).
- `DEBOUNCE`, 3: consecutive cycles a synchronised level must differ from the stable level before it is accepted (1..255).
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pad_in` in `N_PADS`: raw pad levels (IPAD `inpad` outputs), asynchronous.
- `enable_mask` in `N_PADS`: 1 = pad may raise events.
- `evt_valid` out 1: event held on output.
- `evt_ready` in 1: consumer accepts event when high with `evt_valid`.
- `evt_idx` out `$clog2(N_PADS)`: pad index of held event.
- `evt_level` out 1: new stable level of that pad.
- `pad_state` out `N_PADS`: debounced stable level per pad.
- `overflow` out 1: sticky; an event was lost.
- `overflow_clr` in 1: clears `overflow`.

## Operation
- Per pad: a `SYNC_STAGES` flop chain produces `sync[i]`. A counter `cnt[i]` of width `$clog2(DEBOUNCE+1)` increments each cycle `sync[i] != stable[i]` and resets to 0 when they are equal.
- Accept: on the cycle `sync[i] != stable[i]` and `cnt[i] == DEBOUNCE-1`, `stable[i]` toggles and `cnt[i]` clears. A `change[i]` strobe fires that cycle.
- `change[i]` with `enable_mask[i]=1` sets `pending[i]`. `change[i]` with the mask at 0 only updates `stable`. Deasserting `enable_mask[i]` clears `pending[i]` on the next edge.
- Overflow: `change[i]` while `pending[i]=1` and pad i is not being captured this cycle sets `overflow`. `pending[i]` stays 1. The level reported later is `stable[i]` at capture time.
- Output register: it is free when `evt_valid=0` or `evt_valid & evt_ready`. When free and any `pending` bit is set, the arbiter grants the first pending index scanning from `last+1` upward, wrapping modulo `N_PADS`. It then loads `evt_idx`=grant, `evt_level`=`stable[grant]` (post-update value if toggling same edge), `evt_valid`=1, clears `pending[grant]`, and sets `last`=grant.
- If the output register is free and nothing is pending, `evt_valid` falls to 0. `evt_idx` and `evt_level` hold their values.
- Held outputs (`evt_valid`, `evt_idx`, `evt_level`) must not change while `evt_valid & !evt_ready`.
- Same-pad capture and `change` on the same edge: the capture consumes the old pending bit and the new change sets `pending[i]` again. No overflow in this case.
- `overflow_clr` and an overflow-set condition on the same edge: set wins.
- `pad_state` = `stable`.

## Timing
- Reset (async assert, sync deassert by the integrating system): sync chains, `stable`, `cnt`, `pending` = 0. `evt_valid`=0, `evt_idx`=0, `evt_level`=0, `overflow`=0, `last`=`N_PADS-1` (pad 0 has first priority).
- Reset mid-handshake drops the held event and all pending events. No event is generated for pads found high after reset; they produce events only once debounced (0→1 accepted after `SYNC_STAGES+DEBOUNCE` edges).
- Latency: with a pad change first sampled at edge k, `stable` toggles at edge k+`SYNC_STAGES`-1+`DEBOUNCE`. `evt_valid` rises at the next edge if the output register is free. Default: 5 edges.
- Throughput: one event per cycle with `evt_ready` held high.
- Glitch shorter than `DEBOUNCE` cycles at `sync`: no `stable` change, no event.

## Test plan
- Reset with `pad_in`=4'b0000, mask=4'hF, `evt_ready`=1. Raise `pad_in[2]` at edge 0 → `evt_valid`=1, `evt_idx`=2, `evt_level`=1 after edge 5 for one cycle. `pad_state`=4'b0100.
- Pulse `pad_in[1]` high for 2 synchronised cycles (default `DEBOUNCE`=3) → no event, `pad_state` unchanged, `cnt` back to 0.
- `evt_ready`=0, toggle pads 0, 1 and 3 to 1 simultaneously → held event idx 0. Raise ready for one cycle per event → order idx 1, then idx 3. A second toggle of pad 3 before then shows idx 3 with the current level.
- With `evt_ready`=0 holding pad 0, toggle pad 1 twice (1 then 0) → `overflow`=1. Later event for pad 1 reports `evt_level`=0. Pulse `overflow_clr` → `overflow`=0.
- mask=4'b1110, toggle pad 0 → no event, `pad_state[0]` follows. Set pending on pad 2, clear `mask[2]` before grant → no event for pad 2.
- Assert `rst_n`=0 while `evt_valid & !evt_ready` → all outputs 0 immediately. After release, first grant with pads 0 and 3 pending simultaneously goes to pad 0.

Source files
------------

// File: rtl/ipad_event_arb.sv
// ipad_event_arb
// Synchronises and debounces a bank of IPAD input levels, turns every accepted
// level change into an event, and shares the pending events of all pads on one
// valid/ready port through a round-robin arbiter. A sticky flag records events
// that were merged because a pad changed again before its event was delivered.
module ipad_event_arb #(
    parameter int N_PADS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PADS-1:0]         pad_in,
    input  logic [N_PADS-1:0]         enable_mask,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_PADS)-1:0] evt_idx,
    output logic                      evt_level,
    output logic [N_PADS-1:0]         pad_state,
    output logic                      overflow,
    input  logic                      overflow_clr
);

    localparam int IW = $clog2(N_PADS);
    localparam int CW = $clog2(DEBOUNCE + 1);

    // Counter value on which a still-disagreeing level is accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
    // Pointer reset value: the scan then starts at pad 0.
    localparam logic [IW-1:0] IDX_LAST = IW'(N_PADS - 1);

    // Index 'step' positions after 'base', wrapping modulo N_PADS.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        return (sum >= N_PADS) ? IW'(sum - N_PADS) : IW'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [N_PADS-1:0] sync_r [SYNC_STAGES];
    logic [N_PADS-1:0] sync_s;
    logic [CW-1:0]     cnt_r  [N_PADS];
    logic [N_PADS-1:0] stable_r;
    logic [N_PADS-1:0] change_s;
    logic [N_PADS-1:0] stable_next_s;

    // Shift the asynchronous pad levels through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1];

    // A pad changes when it has disagreed with its stable level long enough.
    always_comb begin
        change_s = '0;
        for (int i = 0; i < N_PADS; i++) begin
            change_s[i] = (sync_s[i] != stable_r[i]) && (cnt_r[i] == CNT_LAST);
        end
    end

    // The capture path needs the level as it will be after this edge.
    assign stable_next_s = stable_r ^ change_s;

    // Count disagreement cycles; toggle the stable level on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= '0;
            for (int i = 0; i < N_PADS; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            stable_r <= stable_next_s;
            for (int i = 0; i < N_PADS; i++) begin
                if ((sync_s[i] == stable_r[i]) || change_s[i]) begin
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending events and round-robin arbitration
    // ------------------------------------------------------------------
    logic [N_PADS-1:0] pending_r;
    logic [N_PADS-1:0] pending_next_s;
    logic [IW-1:0]     last_r;
    logic [IW-1:0]     cand_s;
    logic              hit_s;
    logic              grant_found_s;
    logic [IW-1:0]     grant_idx_s;
    logic              out_free_s;
    logic              capture_s;
    logic              ovf_set_s;
    logic              overflow_r;
    logic              evt_valid_r;
    logic [IW-1:0]     evt_idx_r;
    logic              evt_level_r;

    // Find the first pending pad after the most recent grant.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        hit_s         = 1'b0;
        for (int k = 1; k <= N_PADS; k++) begin
            cand_s        = rr_index(last_r, k);
            hit_s         = !grant_found_s && pending_r[cand_s];
            grant_idx_s   = hit_s ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | hit_s;
        end
    end

    // The output register can take a new event when empty or being drained.
    assign out_free_s = !evt_valid_r || evt_ready;
    assign capture_s  = out_free_s && grant_found_s;

    // Next pending set; a change on a pad that still has an undelivered event
    // (and is not being captured right now) means an event is merged away.
    always_comb begin
        pending_next_s = '0;
        ovf_set_s      = 1'b0;
        for (int i = 0; i < N_PADS; i++) begin
            logic cap_v;
            cap_v             = capture_s && (grant_idx_s == IW'(i));
            ovf_set_s         = ovf_set_s | (change_s[i] & enable_mask[i] & pending_r[i] & !cap_v);
            pending_next_s[i] = enable_mask[i] & ((pending_r[i] & !cap_v) | change_s[i]);
        end
    end

    // Pending bits and the sticky overflow flag (a new loss beats a clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= '0;
            overflow_r <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Output event register and round-robin pointer; frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_r <= 1'b0;
            evt_idx_r   <= '0;
            evt_level_r <= 1'b0;
            last_r      <= IDX_LAST;
        end else if (capture_s) begin
            evt_valid_r <= 1'b1;
            evt_idx_r   <= grant_idx_s;
            evt_level_r <= stable_next_s[grant_idx_s];
            last_r      <= grant_idx_s;
        end else if (out_free_s) begin
            evt_valid_r <= 1'b0;
        end else begin
            evt_valid_r <= evt_valid_r;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_idx   = evt_idx_r;
    assign evt_level = evt_level_r;
    assign pad_state = stable_r;
    assign overflow  = overflow_r;

endmodule
